// File: rtl/cs_seq_pkg.sv
// Shared types and constants for the chip-select decode sequencer.
package cs_seq_pkg;
  localparam int CNT_W = 8;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_e;

  // Enable triplet ordering is {g1, g2a_n, g2b_n}
  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b011;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/cs_decode_sequencer_rr_arb8.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module rr_arb8
  import cs_seq_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  logic [N_REQ-1:0] rot;

  for (genvar i = 0; i < N_REQ; i++) begin : g_rot
    assign rot[i] = req[ptr + IDX_W'(i + 1)];
  end

  // Descending scan so the lowest rotated position (closest to ptr+1) wins
  always_comb begin
    idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--)
      if (rot[j]) idx = ptr + IDX_W'(j + 1);
  end

  assign valid = |req;
endmodule

// File: rtl/cs_decode_sequencer.sv
// Round-robin setup/strobe/hold sequencer driving a shared 3-to-8 decoder.
// Optional burst extension of the strobe phase: define CS_SEQ_BURST_EN.
module cs_decode_sequencer
  import cs_seq_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int ACTIVE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int BURST_MAX     = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] done_id_o,
  output logic             select_a_o,
  output logic             select_b_o,
  output logic             select_c_o,
  output logic             g1_en_o,
  output logic             g2a_en_n_o,
  output logic             g2b_en_n_o
);
  localparam int HOLD_LEN = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACT_LD   = CNT_W'(ACTIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_LEN - 1);

  if (ACTIVE_CYCLES < 1 || ACTIVE_CYCLES > 255) begin : g_bad_active
    $error("ACTIVE_CYCLES must be in 1..255");
  end
  if (SETUP_CYCLES < 0 || SETUP_CYCLES > 255 || HOLD_CYCLES < 0 || HOLD_CYCLES > 255
      || BURST_MAX < 0 || BURST_MAX > 255) begin : g_bad_range
    $error("SETUP/HOLD/BURST parameters must be in 0..255");
  end

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] ptr, sel_q, done_id_q, arb_idx;
  logic [N_REQ-1:0] gnt_q;
  logic [2:0]       en_q;
  logic             busy_q, done_q, arb_valid;

  rr_arb8 u_arb (.req(req_i), .ptr(ptr), .valid(arb_valid), .idx(arb_idx));

`ifdef CS_SEQ_BURST_EN
  logic [CNT_W-1:0] burst_cnt;
  logic             burst_go;
  assign burst_go = req_i[sel_q] && (burst_cnt < CNT_W'(BURST_MAX));
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= IDX_W'(N_REQ - 1);
      sel_q     <= '0;
      done_id_q <= '0;
      gnt_q     <= '0;
      en_q      <= EN_OFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CS_SEQ_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (arb_valid) begin
          sel_q  <= arb_idx;
          busy_q <= 1'b1;
`ifdef CS_SEQ_BURST_EN
          burst_cnt <= '0;
`endif
          if (SETUP_CYCLES == 0) begin
            state <= ACTIVE;
            cnt   <= ACT_LD;
            en_q  <= EN_ON;
            gnt_q <= onehot(arb_idx);
          end else begin
            state <= SETUP;
            cnt   <= SETUP_LD;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= ACTIVE;
            cnt   <= ACT_LD;
            en_q  <= EN_ON;
            gnt_q <= onehot(sel_q);
          end else cnt <= cnt - 1'b1;
        end
        ACTIVE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
`ifdef CS_SEQ_BURST_EN
          else if (burst_go) burst_cnt <= burst_cnt + 1'b1;
`endif
          else begin
            state <= HOLD;
            cnt   <= HOLD_LD;
            en_q  <= EN_OFF;
            gnt_q <= '0;
            // done is registered, so it must be raised on entry to the last HOLD cycle
            if (HOLD_LEN == 1) begin
              done_q    <= 1'b1;
              done_id_q <= sel_q;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ptr    <= sel_q;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              done_q    <= 1'b1;
              done_id_q <= sel_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign {select_c_o, select_b_o, select_a_o} = sel_q;
  assign {g1_en_o, g2a_en_n_o, g2b_en_n_o}    = en_q;
endmodule

// File: tb/tb_cs_decode_sequencer.sv
// Scoreboard bench: a transaction-level timing model predicts each grant window.
module tb_cs_decode_sequencer;
  localparam int S  = 1;
  localparam int A  = 2;
  localparam int H  = 1;
  localparam int BM = 4;
  localparam int HL = (H < 1) ? 1 : H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt_o;
  logic       busy_o, done_o, select_a_o, select_b_o, select_c_o;
  logic       g1_en_o, g2a_en_n_o, g2b_en_n_o;
  logic [2:0] done_id_o;

  always #5 clk = ~clk;

  cs_decode_sequencer #(.SETUP_CYCLES(S), .ACTIVE_CYCLES(A), .HOLD_CYCLES(H), .BURST_MAX(BM)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .gnt_o(gnt_o), .busy_o(busy_o),
    .done_o(done_o), .done_id_o(done_id_o), .select_a_o(select_a_o),
    .select_b_o(select_b_o), .select_c_o(select_c_o), .g1_en_o(g1_en_o),
    .g2a_en_n_o(g2a_en_n_o), .g2b_en_n_o(g2b_en_n_o));

  // One expected transaction: sample cycle, active window, done cycle
  typedef struct {
    int idx; int t0; int as; int ae; int td; int extra;
  } txn_t;

  txn_t exp_q[$];
  int   ecnt = 0, next_free = 0, mptr = 7, last_sel = 0;
  int   n_cmp = 0, n_bad = 0;

  // Reference model: cycle ecnt is the cycle that starts at the ecnt-th edge after reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      next_free = 0; mptr = 7; last_sel = 0; ecnt = 0;
    end else begin
      ecnt++;
`ifdef CS_SEQ_BURST_EN
      if (exp_q.size() > 0) begin
        int k;
        k = exp_q.size() - 1;
        if (ecnt == exp_q[k].ae + 1 && req[exp_q[k].idx] && exp_q[k].extra < BM) begin
          exp_q[k].ae++; exp_q[k].td++; exp_q[k].extra++; next_free++;
        end
      end
`endif
      if (ecnt >= next_free && req != 8'h00) begin
        txn_t t;
        int w;
        w = -1;
        for (int k = 1; k <= 8; k++)
          if (w < 0 && req[(mptr + k) % 8]) w = (mptr + k) % 8;
        t.idx = w; t.t0 = ecnt; t.as = ecnt + S; t.ae = ecnt + S + A - 1;
        t.td = t.ae + HL; t.extra = 0;
        exp_q.push_back(t);
        next_free = t.td + 2;
        mptr = w; last_sel = w;
      end
    end
  end

  // Monitor: compares every output against the model once per cycle
  always @(negedge clk) begin
    if (rst_n) begin
      logic [7:0]  eg;
      logic        eb, ed;
      logic [2:0]  een, esel;
      logic [15:0] act, expv;
      txn_t h;
      eg = '0; eb = 1'b0; ed = 1'b0; een = 3'b011; esel = 3'(last_sel);
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        esel = 3'(h.idx);
        eb = (ecnt >= h.t0 && ecnt <= h.td);
        if (ecnt >= h.as && ecnt <= h.ae) begin
          eg = 8'(1) << h.idx;
          een = 3'b100;
        end
        ed = (ecnt == h.td);
      end
      act  = {gnt_o, busy_o, done_o, g1_en_o, g2a_en_n_o, g2b_en_n_o, select_c_o, select_b_o, select_a_o};
      expv = {eg, eb, ed, een, esel};
      n_cmp++;
      if (act !== expv) begin
        n_bad++;
        $display("FAIL cycle%0d outputs {gnt,busy,done,en3,sel3}: got %h expected %h", ecnt, act, expv);
      end
      if (ed) begin
        n_cmp++;
        if (done_id_o !== 3'(h.idx)) begin
          n_bad++;
          $display("FAIL cycle%0d done_id: got %0d expected %0d", ecnt, done_id_o, h.idx);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk_reset(input string name);
    logic [18:0] act;
    act = {gnt_o, busy_o, done_o, done_id_o, select_c_o, select_b_o, select_a_o,
           g1_en_o, g2a_en_n_o, g2b_en_n_o};
    n_cmp++;
    if (act !== {8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 3'b011}) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, {8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 3'b011});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    req = '0;
    repeat (2) @(negedge clk);
    while (busy_o && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (busy_o) begin n_bad++; $display("FAIL drain_timeout: busy got 1 expected 0"); end
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!g1_en_o && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (!g1_en_o) begin n_bad++; $display("FAIL wait_enable_timeout: g1 got 0 expected 1"); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset_values");
    rst_n = 1'b1;

    req = 8'h01;                           // single requester 0
    repeat (6) @(negedge clk);
    drain();

    req = 8'hFF;                           // full contention, rotating order
    repeat (60) @(negedge clk);
    drain();

    req = 8'h20;                           // one-cycle pulse must still complete
    @(negedge clk);
    req = 8'h00;
    drain();

    repeat (400) begin                     // random traffic
      case ($urandom_range(0, 2))
        0: req = 8'h00;
        1: req = 8'(1) << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      @(negedge clk);
    end
    drain();

    req = 8'h5A;                           // reset in the middle of ACTIVE
    wait_en();
    #2 rst_n = 1'b0;
    #1 chk_reset("reset_mid_active");
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h80;
    repeat (3) @(negedge clk);
    drain();

    req = 8'h08;                           // held request (extends under burst build)
    wait_en();
    repeat (10) @(negedge clk);
    drain();

    req = 8'h08;                           // drop request during the first extra cycle
    wait_en();
    @(negedge clk);
    @(negedge clk);
    req = 8'h00;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
